hash_rs: RTL and testbench
==========================

Name: hash_rs

Overview:
Reservation station and issue scheduler for the hash functional unit.
- Buffers up to DEPTH dispatched hash ops.
- Snoops the CDB to capture a pending source operand.
- Issues the oldest ready op to the FU whenever the FU is not busy.
- Sits between the dispatch stage and the hash FU's input_transmit/operand/depvals/wbs/flags/robid inputs.

Parameters:
DEPTH, 4, number of RS entries (power of two, 2..8)
TAGW, 4, width of CDB/producer tag (equals cdb_id width)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
disp_valid  input  1  dispatch offers an op this cycle
disp_ready  output  1  RS has a free entry; dispatch accepted when disp_valid & disp_ready
disp_operand  input  8  opcode/operand byte
disp_src_rdy  input  1  source value already available
disp_src_val  input  8  source value (valid when disp_src_rdy)
disp_src_tag  input  TAGW  producer tag (valid when !disp_src_rdy)
disp_wbs  input  8  writeback selector
disp_flags  input  8  flags
disp_robid  input  4  ROB index
cdb_valid  input  1  CDB broadcast valid
cdb_id  input  TAGW  CDB tag
cdb_val  input  8  CDB value
flush  input  1  discard all entries and any issue in flight
fu_busy  input  1  FU busy (FU output busy)
fu_transmit  output  1  to FU input_transmit
fu_operand  output  8  to FU operand
fu_depvals  output  16  to FU depvals; [7:0] source value, [15:8] driven 0
fu_wbs  output  8  to FU wbs
fu_flags  output  8  to FU flags
fu_robid  output  4  to FU robid
occupancy  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (rst high at posedge): all entries invalid, age state cleared, fu_transmit=0, fu_operand/fu_depvals/fu_wbs/fu_flags/fu_robid=0, occupancy=0. disp_ready=1 the cycle after reset.
- Entry fields: valid, src_rdy, src_tag, src_val, operand, wbs, flags, robid, age rank.
- Dispatch:
  - disp_ready = (occupancy < DEPTH), combinational from registered state; no same-cycle bypass from an issue freeing an entry.
  - On accept, write the lowest-index free entry. The new entry is youngest.
- Wakeup: every valid entry with !src_rdy and src_tag==cdb_id while cdb_valid sets src_rdy=1 and src_val=cdb_val at the edge.
  - An op dispatched the same cycle with !disp_src_rdy and disp_src_tag==cdb_id & cdb_valid is written already ready with cdb_val.
- Issue select:
  - Candidates are valid entries with registered src_rdy=1. A wakeup becomes issuable the cycle after the CDB broadcast.
  - Pick the oldest candidate by dispatch order; ties are impossible.
- Issue:
  - If fu_busy==0, !flush and a candidate exists: at the posedge the selected entry's fields load into the fu_* output registers, fu_transmit=1 for exactly one cycle, and the entry is freed.
  - Otherwise fu_transmit=0 and fu_* data outputs hold 0.
  - fu_busy is high during the issue cycle itself because the FU's busy includes input_transmit, so the maximum issue rate is one op every 2 cycles. This is required behaviour; do not bypass it.
- Latency: a ready op dispatched at edge N with the FU idle drives fu_transmit in cycle N+1 (visible after edge N+1).
- Simultaneous dispatch + issue: both occur; occupancy unchanged.
- Full: disp_ready=0; disp_valid ignored and not recorded.
- Flush: at the edge, all entries are invalidated, fu_transmit forced 0 and occupancy 0.
  - A dispatch in the same cycle as flush is dropped.
  - rst has priority over flush.
- Age ordering must survive any interleaving of dispatch, issue and flush. Implementation choice (age matrix or per-entry counters) is free; observable order is strictly oldest-ready-first.
- No combinational path from fu_busy to any output.

Test Plan:
- Reset then dispatch operand 8'h12, src_rdy=1, src_val=8'h05, wbs=8'h03, robid=4'h2 with fu_busy=0 -> next cycle fu_transmit=1, fu_depvals=16'h0005, fu_wbs=8'h03, fu_robid=4'h2; occupancy returns to 0.
- Dispatch A (tag 4'h7, not ready), then B (ready). -> B issues first. Then drive cdb_valid, cdb_id=4'h7, cdb_val=8'hAA -> A issues no earlier than 2 cycles after the broadcast, with fu_depvals[7:0]=8'hAA.
- Hold fu_busy=1 and dispatch DEPTH ready ops -> disp_ready=0, a 5th dispatch is ignored. Release fu_busy -> ops issue in dispatch order, each fu_transmit pulse separated by at least one idle cycle.
- Dispatch with disp_src_tag=4'h3 not ready in the same cycle as a CDB broadcast of tag 4'h3, value 8'h5C -> entry issues with 8'h5C and does not wait for a later broadcast.
- With 3 entries queued, assert flush together with disp_valid -> occupancy=0, no fu_transmit, disp_ready=1 next cycle; the dispatched op never issues.
- Assert rst mid-stream, with fu_transmit high and entries valid -> after the edge all outputs are 0 and no queued op issues afterwards.

Source files
------------

// File: rtl/hash_rs.sv
// Reservation station and issue scheduler for the hash functional unit.
// Holds up to DEPTH dispatched ops, captures a pending source from the CDB,
// and issues the oldest ready op into registered fu_* outputs.
module hash_rs #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [7:0]                 disp_operand,
    input  logic                       disp_src_rdy,
    input  logic [7:0]                 disp_src_val,
    input  logic [TAGW-1:0]            disp_src_tag,
    input  logic [7:0]                 disp_wbs,
    input  logic [7:0]                 disp_flags,
    input  logic [3:0]                 disp_robid,
    input  logic                       cdb_valid,
    input  logic [TAGW-1:0]            cdb_id,
    input  logic [7:0]                 cdb_val,
    input  logic                       flush,
    input  logic                       fu_busy,
    output logic                       fu_transmit,
    output logic [7:0]                 fu_operand,
    output logic [15:0]                fu_depvals,
    output logic [7:0]                 fu_wbs,
    output logic [7:0]                 fu_flags,
    output logic [3:0]                 fu_robid,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = IW + 1;

    // Entry storage; older_q[i][j] means entry i was dispatched before entry j.
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] src_rdy_q, src_rdy_d;
    logic [TAGW-1:0]  src_tag_q [DEPTH];
    logic [TAGW-1:0]  src_tag_d [DEPTH];
    logic [7:0]       src_val_q [DEPTH];
    logic [7:0]       src_val_d [DEPTH];
    logic [7:0]       operand_q [DEPTH];
    logic [7:0]       operand_d [DEPTH];
    logic [7:0]       wbs_q [DEPTH];
    logic [7:0]       wbs_d [DEPTH];
    logic [7:0]       flags_q [DEPTH];
    logic [7:0]       flags_d [DEPTH];
    logic [3:0]       robid_q [DEPTH];
    logic [3:0]       robid_d [DEPTH];
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];

    logic             fu_transmit_q, fu_transmit_d;
    logic [7:0]       fu_operand_q, fu_operand_d;
    logic [15:0]      fu_depvals_q, fu_depvals_d;
    logic [7:0]       fu_wbs_q, fu_wbs_d;
    logic [7:0]       fu_flags_q, fu_flags_d;
    logic [3:0]       fu_robid_q, fu_robid_d;

    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] is_oldest;
    logic [IW-1:0]    sel_idx;
    logic [IW-1:0]    free_idx;
    logic [OW-1:0]    occ;
    logic             accept;
    logic             issue;
    logic             disp_cdb_hit;

    assign cand         = valid_q & src_rdy_q;
    assign disp_ready   = ~&valid_q;
    assign accept       = disp_valid & disp_ready & ~flush;
    assign issue        = ~fu_busy & ~flush & (|cand);
    assign disp_cdb_hit = ~disp_src_rdy & cdb_valid & (disp_src_tag == cdb_id);

    // An entry is the oldest candidate when no other candidate is older than it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [DEPTH-1:0] older_than_me;
        // Gather column gi of the age matrix.
        always_comb begin
            older_than_me = '0;
            for (int j = 0; j < DEPTH; j++) older_than_me[j] = older_q[j][gi];
        end
        assign is_oldest[gi] = cand[gi] & ~|(cand & older_than_me);
    end

    // Encode the issue slot, the lowest free slot and the occupancy count.
    always_comb begin
        sel_idx  = '0;
        free_idx = '0;
        occ      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (is_oldest[i]) sel_idx = IW'(i);
            occ = occ + OW'(valid_q[i]);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IW'(i);
        end
    end

    // Next state: wakeup, issue, dispatch, then flush overrides validity.
    always_comb begin
        valid_d       = valid_q;
        src_rdy_d     = src_rdy_q;
        src_tag_d     = src_tag_q;
        src_val_d     = src_val_q;
        operand_d     = operand_q;
        wbs_d         = wbs_q;
        flags_d       = flags_q;
        robid_d       = robid_q;
        older_d       = older_q;
        fu_transmit_d = 1'b0;
        fu_operand_d  = '0;
        fu_depvals_d  = '0;
        fu_wbs_d      = '0;
        fu_flags_d    = '0;
        fu_robid_d    = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !src_rdy_q[i] && cdb_valid && (src_tag_q[i] == cdb_id)) begin
                src_rdy_d[i] = 1'b1;
                src_val_d[i] = cdb_val;
            end
        end

        if (issue) begin
            valid_d[sel_idx] = 1'b0;
            fu_transmit_d    = 1'b1;
            fu_operand_d     = operand_q[sel_idx];
            fu_depvals_d     = {8'h00, src_val_q[sel_idx]};
            fu_wbs_d         = wbs_q[sel_idx];
            fu_flags_d       = flags_q[sel_idx];
            fu_robid_d       = robid_q[sel_idx];
        end

        if (accept) begin
            valid_d[free_idx]   = 1'b1;
            src_rdy_d[free_idx] = disp_src_rdy | disp_cdb_hit;
            src_val_d[free_idx] = disp_src_rdy ? disp_src_val : cdb_val;
            src_tag_d[free_idx] = disp_src_tag;
            operand_d[free_idx] = disp_operand;
            wbs_d[free_idx]     = disp_wbs;
            flags_d[free_idx]   = disp_flags;
            robid_d[free_idx]   = disp_robid;
            // Every currently valid entry is older than the newcomer.
            older_d[free_idx]   = '0;
            for (int j = 0; j < DEPTH; j++) older_d[j][free_idx] = valid_q[j];
        end

        if (flush) valid_d = '0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            src_rdy_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                src_tag_q[i] <= '0;
                src_val_q[i] <= '0;
                operand_q[i] <= '0;
                wbs_q[i]     <= '0;
                flags_q[i]   <= '0;
                robid_q[i]   <= '0;
                older_q[i]   <= '0;
            end
            fu_transmit_q <= 1'b0;
            fu_operand_q  <= '0;
            fu_depvals_q  <= '0;
            fu_wbs_q      <= '0;
            fu_flags_q    <= '0;
            fu_robid_q    <= '0;
        end else begin
            valid_q       <= valid_d;
            src_rdy_q     <= src_rdy_d;
            src_tag_q     <= src_tag_d;
            src_val_q     <= src_val_d;
            operand_q     <= operand_d;
            wbs_q         <= wbs_d;
            flags_q       <= flags_d;
            robid_q       <= robid_d;
            older_q       <= older_d;
            fu_transmit_q <= fu_transmit_d;
            fu_operand_q  <= fu_operand_d;
            fu_depvals_q  <= fu_depvals_d;
            fu_wbs_q      <= fu_wbs_d;
            fu_flags_q    <= fu_flags_d;
            fu_robid_q    <= fu_robid_d;
        end
    end

    assign fu_transmit = fu_transmit_q;
    assign fu_operand  = fu_operand_q;
    assign fu_depvals  = fu_depvals_q;
    assign fu_wbs      = fu_wbs_q;
    assign fu_flags    = fu_flags_q;
    assign fu_robid    = fu_robid_q;
    assign occupancy   = occ;

endmodule

// File: tb/tb_hash_rs.sv
// Directed self-checking bench for hash_rs (DEPTH=4, TAGW=4).
module tb_hash_rs;
    logic        clk = 1'b0;
    logic        rst;
    logic        disp_valid;
    logic        disp_ready;
    logic [7:0]  disp_operand;
    logic        disp_src_rdy;
    logic [7:0]  disp_src_val;
    logic [3:0]  disp_src_tag;
    logic [7:0]  disp_wbs;
    logic [7:0]  disp_flags;
    logic [3:0]  disp_robid;
    logic        cdb_valid;
    logic [3:0]  cdb_id;
    logic [7:0]  cdb_val;
    logic        flush;
    logic        fu_busy;
    logic        fu_transmit;
    logic [7:0]  fu_operand;
    logic [15:0] fu_depvals;
    logic [7:0]  fu_wbs;
    logic [7:0]  fu_flags;
    logic [3:0]  fu_robid;
    logic [2:0]  occupancy;
    logic        busy_force;

    int passed = 0;
    int total  = 0;

    // FU busy model: busy during its own input_transmit cycle, or when forced.
    assign fu_busy = fu_transmit | busy_force;

    always #5 clk = ~clk;

    hash_rs #(.DEPTH(4), .TAGW(4)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_operand(disp_operand), .disp_src_rdy(disp_src_rdy),
        .disp_src_val(disp_src_val), .disp_src_tag(disp_src_tag),
        .disp_wbs(disp_wbs), .disp_flags(disp_flags), .disp_robid(disp_robid),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
        .flush(flush), .fu_busy(fu_busy),
        .fu_transmit(fu_transmit), .fu_operand(fu_operand),
        .fu_depvals(fu_depvals), .fu_wbs(fu_wbs), .fu_flags(fu_flags),
        .fu_robid(fu_robid), .occupancy(occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_disp(input logic [7:0] op, input logic rdy, input logic [7:0] val,
                            input logic [3:0] tag, input logic [7:0] wbs,
                            input logic [7:0] flg, input logic [3:0] rob);
        disp_valid   = 1'b1;
        disp_operand = op;
        disp_src_rdy = rdy;
        disp_src_val = val;
        disp_src_tag = tag;
        disp_wbs     = wbs;
        disp_flags   = flg;
        disp_robid   = rob;
    endtask

    task automatic chk_issue(input string tag, input logic [7:0] op, input logic [7:0] val,
                             input logic [7:0] wbs, input logic [7:0] flg, input logic [3:0] rob);
        $display("issue %s: transmit=%0d operand=%h depvals=%h wbs=%h flags=%h robid=%h",
                 tag, fu_transmit, fu_operand, fu_depvals, fu_wbs, fu_flags, fu_robid);
        chk({tag, "_tx"},      32'(fu_transmit), 32'd1);
        chk({tag, "_operand"}, 32'(fu_operand),  32'(op));
        chk({tag, "_depvals"}, 32'(fu_depvals),  32'({8'h00, val}));
        chk({tag, "_wbs"},     32'(fu_wbs),      32'(wbs));
        chk({tag, "_flags"},   32'(fu_flags),    32'(flg));
        chk({tag, "_robid"},   32'(fu_robid),    32'(rob));
    endtask

    task automatic wait_issue(input string tag, input int budget);
        int n = 0;
        while (fu_transmit !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 32'(fu_transmit), 32'd1);
    endtask

    initial begin
        rst = 1'b1; disp_valid = 1'b0; disp_operand = '0; disp_src_rdy = 1'b0;
        disp_src_val = '0; disp_src_tag = '0; disp_wbs = '0; disp_flags = '0;
        disp_robid = '0; cdb_valid = 1'b0; cdb_id = '0; cdb_val = '0;
        flush = 1'b0; busy_force = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_tx",      32'(fu_transmit), 32'd0);
        chk("rst_depvals", 32'(fu_depvals),  32'd0);
        chk("rst_robid",   32'(fu_robid),    32'd0);
        chk("rst_occ",     32'(occupancy),   32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready",   32'(disp_ready),  32'd1);

        // Single ready op: one-cycle dispatch-to-issue latency
        set_disp(8'h12, 1'b1, 8'h05, 4'h0, 8'h03, 8'h44, 4'h2);
        tick();
        disp_valid = 1'b0;
        chk("t1_occ1", 32'(occupancy),   32'd1);
        chk("t1_tx0",  32'(fu_transmit), 32'd0);
        tick();
        chk_issue("t1", 8'h12, 8'h05, 8'h03, 8'h44, 4'h2);
        chk("t1_occ0", 32'(occupancy),   32'd0);
        tick();
        chk("t1_tx_off",   32'(fu_transmit), 32'd0);
        chk("t1_data_off", 32'(fu_depvals),  32'd0);

        // A waits on tag 7, B ready: B goes first, A after the broadcast
        set_disp(8'hA1, 1'b0, 8'h00, 4'h7, 8'h0A, 8'h01, 4'h3);
        tick();
        set_disp(8'hB2, 1'b1, 8'h0B, 4'h0, 8'h0B, 8'h02, 4'h4);
        tick();
        disp_valid = 1'b0;
        tick();
        chk_issue("t2_B", 8'hB2, 8'h0B, 8'h0B, 8'h02, 4'h4);
        tick();
        chk("t2_idle", 32'(fu_transmit), 32'd0);
        cdb_valid = 1'b1; cdb_id = 4'h7; cdb_val = 8'hAA;
        tick();
        cdb_valid = 1'b0;
        chk("t2_no_early", 32'(fu_transmit), 32'd0);
        tick();
        chk_issue("t2_A", 8'hA1, 8'hAA, 8'h0A, 8'h01, 4'h3);
        tick();
        chk("t2_occ0", 32'(occupancy), 32'd0);

        // Fill while FU busy; fifth dispatch ignored; drain in order
        busy_force = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_disp(8'h20 + 8'(k), 1'b1, 8'h10 + 8'(k), 4'h0, 8'h30 + 8'(k), 8'h00, 4'h8 + 4'(k));
            tick();
        end
        chk("t3_full_ready", 32'(disp_ready), 32'd0);
        chk("t3_full_occ",   32'(occupancy),  32'd4);
        set_disp(8'hFF, 1'b1, 8'hEE, 4'h0, 8'hDD, 8'h00, 4'hF);
        tick();
        disp_valid = 1'b0;
        chk("t3_fifth_ign", 32'(occupancy), 32'd4);
        chk("t3_busy_tx",   32'(fu_transmit), 32'd0);
        busy_force = 1'b0;
        wait_issue("t3_i0", 4);
        chk_issue("t3_i0", 8'h20, 8'h10, 8'h30, 8'h00, 4'h8);
        tick();
        chk("t3_gap0", 32'(fu_transmit), 32'd0);
        wait_issue("t3_i1", 4);
        chk_issue("t3_i1", 8'h21, 8'h11, 8'h31, 8'h00, 4'h9);
        tick();
        chk("t3_gap1", 32'(fu_transmit), 32'd0);
        wait_issue("t3_i2", 4);
        chk_issue("t3_i2", 8'h22, 8'h12, 8'h32, 8'h00, 4'hA);
        tick();
        chk("t3_gap2", 32'(fu_transmit), 32'd0);
        wait_issue("t3_i3", 4);
        chk_issue("t3_i3", 8'h23, 8'h13, 8'h33, 8'h00, 4'hB);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_no_fifth", 32'(fu_transmit), 32'd0);
        end
        chk("t3_occ0", 32'(occupancy), 32'd0);

        // Dispatch-time wakeup from a same-cycle CDB broadcast
        set_disp(8'h55, 1'b0, 8'h00, 4'h3, 8'h66, 8'h77, 4'h5);
        cdb_valid = 1'b1; cdb_id = 4'h3; cdb_val = 8'h5C;
        tick();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        chk("t4_occ1", 32'(occupancy), 32'd1);
        tick();
        chk_issue("t4", 8'h55, 8'h5C, 8'h66, 8'h77, 4'h5);
        tick();

        // Flush with three queued plus a same-cycle dispatch
        busy_force = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_disp(8'h40 + 8'(k), 1'b1, 8'h01, 4'h0, 8'h00, 8'h00, 4'h1 + 4'(k));
            tick();
        end
        chk("t5_occ3", 32'(occupancy), 32'd3);
        set_disp(8'h4F, 1'b1, 8'h02, 4'h0, 8'h00, 8'h00, 4'h6);
        flush = 1'b1;
        tick();
        flush = 1'b0; disp_valid = 1'b0; busy_force = 1'b0;
        chk("t5_occ0",  32'(occupancy),   32'd0);
        chk("t5_tx0",   32'(fu_transmit), 32'd0);
        chk("t5_ready", 32'(disp_ready),  32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_no_issue", 32'(fu_transmit), 32'd0);
        end

        // Reset mid-stream while an issue is visible and entries remain
        busy_force = 1'b1;
        set_disp(8'h71, 1'b1, 8'h17, 4'h0, 8'h01, 8'h00, 4'h7);
        tick();
        set_disp(8'h72, 1'b1, 8'h18, 4'h0, 8'h02, 8'h00, 4'h9);
        tick();
        disp_valid = 1'b0; busy_force = 1'b0;
        tick();
        chk_issue("t6_pre", 8'h71, 8'h17, 8'h01, 8'h00, 4'h7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_tx0",     32'(fu_transmit), 32'd0);
        chk("t6_operand", 32'(fu_operand),  32'd0);
        chk("t6_depvals", 32'(fu_depvals),  32'd0);
        chk("t6_robid",   32'(fu_robid),    32'd0);
        chk("t6_occ0",    32'(occupancy),   32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_no_issue", 32'(fu_transmit), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
